// File: rtl/dft_mc_scan_ctrl.sv
// Multi-chain scan dump controller: shifts NUM_CHAINS chains, packs scan-out into OUT_W words, streams them.
// Optional DFT_CHAIN_MASK_EN adds chain_mask to skip chains during word emission.
module dft_mc_scan_ctrl #(
   parameter int NUM_CHAINS = 4,
   parameter int CHAIN_LEN  = 32,
   parameter int OUT_W      = 32,
   localparam int CW = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
   localparam int BW = $clog2(CHAIN_LEN + 1),
   localparam int WW = $clog2(OUT_W + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  val_op,
   input  logic [1:0]            op,
`ifdef DFT_CHAIN_MASK_EN
   input  logic [NUM_CHAINS-1:0] chain_mask,
`endif
   output logic                  op_ack,
   output logic                  op_commit,
   input  logic                  commit_ack,
   output logic                  sc_sen,
   output logic                  sc_ce,
   input  logic [NUM_CHAINS-1:0] sc_sout,
   output logic [NUM_CHAINS-1:0] sc_sin,
   output logic [OUT_W-1:0]      dft_out,
   output logic [CW-1:0]         dft_out_chain,
   output logic                  dft_out_strobe,
   input  logic                  dft_out_rdy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_EMIT, S_COMMIT} state_t;

   state_t                           r_state, w_state_nxt;
   logic                             r_dump;
   logic                             r_op_ack;
   logic [BW-1:0]                    r_bit_cnt;
   logic [WW-1:0]                    r_wbit;
   logic [NUM_CHAINS-1:0][OUT_W-1:0] r_coll;
   logic [CW-1:0]                    r_chain;
   logic [NUM_CHAINS-1:0]            w_mask;
   logic                             w_last_shift, w_word_full, w_any_emit;
   logic                             w_nxt_found, w_first_found;
   logic [CW-1:0]                    w_nxt_idx, w_first_idx;
   logic [OUT_W-1:0]                 w_out;

`ifdef DFT_CHAIN_MASK_EN
   logic [NUM_CHAINS-1:0] r_mask;
   assign w_mask = r_mask;
`else
   assign w_mask = '0;
`endif

   assign w_last_shift = (r_bit_cnt == BW'(CHAIN_LEN - 1));
   assign w_word_full  = (r_wbit == WW'(OUT_W - 1));
   assign w_any_emit   = r_dump && w_first_found;

   // Lowest unmasked chain overall, and lowest unmasked chain above the one being presented.
   always_comb begin
      w_nxt_found   = 1'b0;
      w_nxt_idx     = '0;
      w_first_found = 1'b0;
      w_first_idx   = '0;
      for (int i = NUM_CHAINS - 1; i >= 0; i--) begin
         if (!w_mask[i]) begin
            w_first_found = 1'b1;
            w_first_idx   = CW'(i);
            if (CW'(i) > r_chain) begin
               w_nxt_found = 1'b1;
               w_nxt_idx   = CW'(i);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (val_op) w_state_nxt = (op == 2'b01 || op == 2'b10) ? S_SHIFT : S_COMMIT;
         S_SHIFT:
            if (w_last_shift || w_word_full) begin
               if (w_any_emit)        w_state_nxt = S_EMIT;
               else if (w_last_shift) w_state_nxt = S_COMMIT;
            end
         S_EMIT:
            if (dft_out_rdy && !w_nxt_found)
               w_state_nxt = (r_bit_cnt == BW'(CHAIN_LEN)) ? S_COMMIT : S_SHIFT;
         S_COMMIT:
            if (commit_ack) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_out = '0;
      for (int c = 0; c < NUM_CHAINS; c++)
         if (r_chain == CW'(c)) w_out = r_coll[c];
   end

   assign op_ack         = r_op_ack;
   assign op_commit      = (r_state == S_COMMIT);
   assign sc_sen         = (r_state == S_SHIFT) || (r_state == S_EMIT);
   assign sc_ce          = (r_state == S_SHIFT);
   assign sc_sin         = (sc_ce && r_dump) ? sc_sout : '0;
   assign dft_out_strobe = (r_state == S_EMIT);
   assign dft_out        = dft_out_strobe ? w_out : '0;
   assign dft_out_chain  = dft_out_strobe ? r_chain : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_dump    <= 1'b0;
         r_op_ack  <= 1'b0;
         r_bit_cnt <= '0;
         r_wbit    <= '0;
         r_coll    <= '0;
         r_chain   <= '0;
`ifdef DFT_CHAIN_MASK_EN
         r_mask    <= '0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_op_ack <= (r_state == S_IDLE) && val_op;
         case (r_state)
            S_IDLE:
               if (val_op) begin
                  r_dump    <= (op == 2'b01);
                  r_bit_cnt <= '0;
                  r_wbit    <= '0;
                  r_coll    <= '0;
                  r_chain   <= '0;
`ifdef DFT_CHAIN_MASK_EN
                  r_mask    <= chain_mask;
`endif
               end
            S_SHIFT: begin
               for (int c = 0; c < NUM_CHAINS; c++)
                  for (int b = 0; b < OUT_W; b++)
                     if (r_wbit == WW'(b)) r_coll[c][b] <= sc_sout[c];
               r_bit_cnt <= r_bit_cnt + BW'(1);
               r_wbit    <= r_wbit + WW'(1);
               // Word boundary with nothing to emit (FLUSH / all masked): restart packing in place.
               if (w_last_shift || w_word_full) begin
                  if (w_any_emit) r_chain <= w_first_idx;
                  else            r_wbit  <= '0;
               end
            end
            S_EMIT:
               if (dft_out_rdy) begin
                  if (w_nxt_found) begin
                     r_chain <= w_nxt_idx;
                  end else begin
                     r_coll  <= '0;
                     r_wbit  <= '0;
                     r_chain <= '0;
                  end
               end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dft_mc_scan_ctrl.md
Name: dft_mc_scan_ctrl

Overview:
- Multi-chain scan dump controller; next generation of the single-chain DFT controller/datapath pair.
- Drives scan enable and scan clock-enable into a DUT with NUM_CHAINS parallel scan chains.
- Collects each chain's scan-out into OUT_W-bit words and streams them out with a valid/ready handshake.
- Recirculates scan-out to scan-in (DUMP, non-destructive) or shifts zeros in (FLUSH); fronted by the val_op/op_ack/op_commit/commit_ack handshake used across the DFT blocks.

Parameters:
- NUM_CHAINS, 4: number of parallel scan chains (>=1).
- CHAIN_LEN, 32: flops per chain (>=1); all chains equal length.
- OUT_W, 32: output word width (>=1; need not divide CHAIN_LEN).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- val_op  in  1  operation request.
- op  in  2  operation code: 01 DUMP, 10 FLUSH, 00/11 NOP.
- op_ack  out  1  one-cycle request-accepted pulse.
- op_commit  out  1  operation finished; held until commit_ack.
- commit_ack  in  1  commit acknowledge.
- sc_sen  out  1  scan enable to DUT.
- sc_ce  out  1  scan clock-enable to DUT (one shift per cycle high).
- sc_sout  in  NUM_CHAINS  scan-out bit per chain.
- sc_sin  out  NUM_CHAINS  scan-in bit per chain.
- dft_out  out  OUT_W  dump word.
- dft_out_chain  out  clog2(NUM_CHAINS) (min 1)  chain index of dft_out.
- dft_out_strobe  out  1  dft_out valid.
- dft_out_rdy  in  1  consumer ready.

Behaviour:
- Reset (synchronous, active-high): state IDLE. op_ack, op_commit, sc_sen, sc_ce, dft_out_strobe = 0. dft_out = 0, dft_out_chain = 0, all collectors and counters = 0.
- States: IDLE, SHIFT, EMIT, COMMIT.
- IDLE:
  - val_op sampled high at edge k: op latched; op_ack = 1 for cycle k+1 only.
  - Next state: SHIFT for DUMP/FLUSH; COMMIT for NOP.
  - val_op outside IDLE is ignored; op_ack is never raised outside IDLE.
- SHIFT:
  - sc_sen = 1, sc_ce = 1 every cycle.
  - Each cycle, collector[c] bit[wbit] <= sc_sout[c]; bit_cnt++ and wbit++.
  - First bit out of a chain lands in bit 0 of word 0.
  - DUMP: sc_sin = sc_sout (combinational recirculate). FLUSH: sc_sin = 0.
  - Goes to EMIT when wbit reaches OUT_W or bit_cnt reaches CHAIN_LEN; that shift is the last one before EMIT.
  - FLUSH never enters EMIT; after CHAIN_LEN shifts it goes to COMMIT.
- EMIT:
  - sc_ce = 0, sc_sen = 1 (chain frozen, not released).
  - Presents collector[0..NUM_CHAINS-1] in ascending chain order.
  - dft_out_strobe = 1 with dft_out and dft_out_chain stable until dft_out_rdy is sampled high; then advance to the next chain (no idle cycle).
  - Partial last word: unfilled upper bits are 0.
  - After the last chain's word is accepted: clear collectors and wbit. Return to SHIFT if bit_cnt < CHAIN_LEN, else go to COMMIT.
- COMMIT:
  - sc_sen = sc_ce = 0; op_commit = 1 until commit_ack is sampled high, then IDLE next cycle.
  - commit_ack outside COMMIT is ignored.
- Counts:
  - Total shifts per DUMP/FLUSH = CHAIN_LEN exactly.
  - Words per chain = ceil(CHAIN_LEN/OUT_W).
  - Minimum DUMP duration: CHAIN_LEN + NUM_CHAINS*ceil(CHAIN_LEN/OUT_W) cycles with rdy tied high.
  - After a DUMP, chain contents equal their pre-op contents.
- Reset mid-op: returns to IDLE immediately; no further strobe or commit. Chain contents are undefined (partially rotated).
- Counter widths: bit_cnt clog2(CHAIN_LEN+1), wbit clog2(OUT_W+1); no wrap within an op.

Optional Feature:
- DFT_CHAIN_MASK_EN defined:
  - Adds input chain_mask [NUM_CHAINS]; sampled with op at acceptance and held for the op.
  - Masked chains (bit = 1) still shift and recirculate but are skipped in EMIT (no strobe).
  - All chains masked: DUMP behaves as FLUSH timing-wise but with recirculation.
- Not defined: port absent; every chain is emitted.

Test Plan:
- NUM_CHAINS=2, CHAIN_LEN=8, OUT_W=4; chain0=0xA5, chain1=0x3C (bit0 out first); DUMP with rdy=1 -> words (ch0,0x5),(ch1,0xC),(ch0,0xA),(ch1,0x3); 8 shift cycles; op_commit; chains read back 0xA5/0x3C.
- Same configuration with CHAIN_LEN=6 -> words (0,0x5),(1,0xC),(0,0x2),(1,0x3); partial-word upper bits are 0.
- FLUSH on chain0=0xFF -> exactly 8 sc_ce cycles, sc_sin=0, no dft_out_strobe; subsequent DUMP emits all-zero words.
- dft_out_rdy low for 5 cycles mid-EMIT -> dft_out/dft_out_chain stable, sc_ce=0 throughout; resumes on rdy.
- val_op during SHIFT and commit_ack during SHIFT -> ignored. op=00 -> op_ack then op_commit with no shift. reset asserted in EMIT -> all outputs 0 next cycle, state IDLE.
- DFT_CHAIN_MASK_EN, chain_mask=2'b01 -> only chain1 words strobed; chain0 still restored to 0xA5.
